// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for a 5-stage in-order pipeline.
// Produces a thermometer stall vector (deepest hazard wins), branch flush
// strobes, and a free-running count of stalled cycles.
module pipe_stall_ctrl #(
    parameter int MEM_WAIT  = 2,
    parameter int EX_CYCLES = 3,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_multi,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    output logic [5:0]  stall,
    output logic        flush_id,
    output logic        flush_ex,
    output logic [31:0] stall_cycles
);

    typedef enum logic [0:0] {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_t;

    typedef enum logic [0:0] {
        E_IDLE = 1'b0,
        E_BUSY = 1'b1
    } ex_state_t;

    // A zero wait parameter disables the corresponding FSM entirely.
    localparam bit               MEM_EN   = (MEM_WAIT > 0);
    localparam bit               EX_EN    = (EX_CYCLES > 0);
    // Counter reload is N-1: the entry cycle already counts as one stall.
    localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);
    localparam logic [CNT_W-1:0] EX_LOAD  = CNT_W'((EX_CYCLES > 0) ? (EX_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    mem_state_t       m_state_r, m_state_n;
    ex_state_t        e_state_r, e_state_n;
    logic [CNT_W-1:0] mcnt_r, mcnt_n;
    logic [CNT_W-1:0] ecnt_r, ecnt_n;
    logic [31:0]      stall_cycles_r;

    logic             mem_stall_s;
    logic             ex_busy_s;
    logic             ex_held_s;
    logic             load_use_s;
    logic             flush_s;
    logic [5:0]       stall_s;
    ex_state_t        e_state_adv_s;
    logic [CNT_W-1:0] ecnt_adv_s;

    // MEM wait-state FSM: next state, counter and mem stall request.
    always_comb begin
        m_state_n   = m_state_r;
        mcnt_n      = mcnt_r;
        mem_stall_s = 1'b0;
        case (m_state_r)
            M_IDLE: begin
                if (mem_req && MEM_EN) begin
                    mem_stall_s = 1'b1;
                    m_state_n   = M_WAIT;
                    mcnt_n      = MEM_LOAD;
                end else begin
                    m_state_n   = M_IDLE;
                end
            end
            M_WAIT: begin
                if (mcnt_r != CNT_ZERO) begin
                    mem_stall_s = 1'b1;
                    mcnt_n      = mcnt_r - CNT_ONE;
                end else begin
                    // Final cycle: the access completes and leaves MEM.
                    m_state_n   = M_IDLE;
                end
            end
            default: begin
                m_state_n = M_IDLE;
                mcnt_n    = CNT_ZERO;
            end
        endcase
    end

    // EX multi-cycle FSM: busy request and advance, frozen while MEM stalls.
    always_comb begin
        e_state_adv_s = e_state_r;
        ecnt_adv_s    = ecnt_r;
        ex_busy_s     = 1'b0;
        case (e_state_r)
            E_IDLE: begin
                if (ex_multi && EX_EN) begin
                    ex_busy_s     = 1'b1;
                    e_state_adv_s = E_BUSY;
                    ecnt_adv_s    = EX_LOAD;
                end else begin
                    e_state_adv_s = E_IDLE;
                end
            end
            E_BUSY: begin
                if (ecnt_r != CNT_ZERO) begin
                    ex_busy_s  = 1'b1;
                    ecnt_adv_s = ecnt_r - CNT_ONE;
                end else begin
                    e_state_adv_s = E_IDLE;
                end
            end
            default: begin
                e_state_adv_s = E_IDLE;
                ecnt_adv_s    = CNT_ZERO;
            end
        endcase
        if (mem_stall_s) begin
            e_state_n = e_state_r;
            ecnt_n    = ecnt_r;
        end else begin
            e_state_n = e_state_adv_s;
            ecnt_n    = ecnt_adv_s;
        end
    end

    // Hazard detection, flush generation and priority stall encoding.
    always_comb begin
        ex_held_s  = mem_stall_s || ex_busy_s;
        flush_s    = ex_branch_taken && !ex_held_s;
        load_use_s = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));
        if (mem_stall_s) begin
            stall_s = 6'b011111;
        end else if (ex_busy_s) begin
            stall_s = 6'b001111;
        end else if (load_use_s && !flush_s) begin
            // A flushed ID instruction is wrong-path, so its hazard is moot.
            stall_s = 6'b000111;
        end else begin
            stall_s = 6'b000000;
        end
    end

    // Output gating: everything reads as quiet while reset is held.
    always_comb begin
        if (rst) begin
            stall    = 6'b000000;
            flush_id = 1'b0;
            flush_ex = 1'b0;
        end else begin
            stall    = stall_s;
            flush_id = flush_s;
            flush_ex = flush_s;
        end
    end

    // FSM state and wait counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state_r <= M_IDLE;
            e_state_r <= E_IDLE;
            mcnt_r    <= CNT_ZERO;
            ecnt_r    <= CNT_ZERO;
        end else begin
            m_state_r <= m_state_n;
            e_state_r <= e_state_n;
            mcnt_r    <= mcnt_n;
            ecnt_r    <= ecnt_n;
        end
    end

    // Stall-cycle performance counter, wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_r <= 32'd0;
        end else if (stall_s != 6'b000000) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a driver applies directed and random
// stimulus and pushes expectations from a cycle-count reference model; a
// separate monitor pops and compares each cycle.
module tb_pipe_stall_ctrl;

    localparam int MW = 2;
    localparam int EC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_multi, ex_branch_taken, mem_req;
    logic [5:0]  stall;
    logic        flush_id, flush_ex;
    logic [31:0] stall_cycles;

    pipe_stall_ctrl #(.MEM_WAIT(MW), .EX_CYCLES(EC), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_multi        (ex_multi),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .stall           (stall),
        .flush_id        (flush_id),
        .flush_ex        (flush_ex),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // Reference model: remaining stall cycles per hazard plus a "leaving" flag.
    int          mem_left = 0;
    int          ex_left  = 0;
    bit          mem_done = 1'b0;
    bit          ex_done  = 1'b0;
    logic [31:0] cnt_model = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mem_left  = 0;
        ex_left   = 0;
        mem_done  = 1'b0;
        ex_done   = 1'b0;
        cnt_model = 32'd0;
    endtask

    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic mul, input logic tk, input logic mq);
        int         el;
        bit         ms, es, lu, fl;
        logic [5:0] sv;
        exp_t       e;
        @(negedge clk);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_multi = mul; ex_branch_taken = tk; mem_req = mq;
        // A new memory access costs MW stalled cycles, then one leaving cycle.
        if (!mem_done && mem_left == 0 && mq) mem_left = MW;
        ms = (mem_left > 0);
        el = ex_left;
        if (!ex_done && ex_left == 0 && mul) el = EC;
        es = (el > 0);
        lu = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        fl = tk && !(ms || es);
        if (ms)            sv = 6'b011111;
        else if (es)       sv = 6'b001111;
        else if (lu && !fl) sv = 6'b000111;
        else               sv = 6'b000000;
        e.stall = sv; e.flush = fl; e.cnt = cnt_model;
        q.push_back(e);
        if (sv != 6'b000000) cnt_model = cnt_model + 32'd1;
        if (ms) begin
            mem_left--;
            if (mem_left == 0) mem_done = 1'b1;
        end else if (mem_done) begin
            mem_done = 1'b0;
        end
        if (!ms) begin
            ex_left = el;
            if (es) begin
                ex_left--;
                if (ex_left == 0) ex_done = 1'b1;
            end else if (ex_done) begin
                ex_done = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare the DUT outputs against the oldest expectation.
    always @(negedge clk) begin
        #2;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            tests++;
            if (stall !== mon_e.stall || flush_id !== mon_e.flush ||
                flush_ex !== mon_e.flush || stall_cycles !== mon_e.cnt) begin
                fails++;
                $display("FAIL cycle_check t=%0t: stall=%b fid=%b fex=%b cnt=%h, expected stall=%b flush=%b cnt=%h",
                         $time, stall, flush_id, flush_ex, stall_cycles,
                         mon_e.stall, mon_e.flush, mon_e.cnt);
            end
        end
    end

    initial begin
        rst = 1'b1;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_multi = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_stall", {26'd0, stall}, 32'd0);
        chk("reset_flush", {30'd0, flush_id, flush_ex}, 32'd0);
        chk("reset_cnt", stall_cycles, 32'd0);
        mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Load-use hazard, then same with ex_rd = x0.
        step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(5'd9, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Single memory access, then back-to-back accesses.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        for (int i = 0; i < 6; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Multi-cycle EX, then EX together with a memory access.
        for (int i = 0; i < 4; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Taken branch suppresses load-use; then held by a busy EX.
        step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Asynchronous reset in the middle of a memory wait (mcnt = 1).
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_stall", {26'd0, stall}, 32'd0);
        chk("async_rst_flush", {30'd0, flush_id, flush_ex}, 32'd0);
        chk("async_rst_cnt", stall_cycles, 32'd0);
        model_reset();
        @(negedge clk);
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_multi = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0;
        rst = 1'b0;
        idle(2);

        // Counter wrap from all-ones.
        idle(8);
        #3;
        force dut.stall_cycles_r = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles_r;
        cnt_model = 32'hFFFF_FFFF;
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 4) == 0));
        end
        idle(2);

        repeat (2) @(negedge clk);
        #3;
        chk("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline (PC, IF, ID, EX, MEM, WB).
- Generates the 6-bit stall vector consumed by every pipeline register, plus branch flush strobes.
- Sources:
  - load-use hazard detected in ID;
  - multi-cycle EX operations;
  - wait-stated data-memory accesses in MEM;
  - taken branches resolved in EX.
- Also keeps a stall-cycle performance counter.

Parameters:
- MEM_WAIT, 2, extra stall cycles per data-memory access in MEM (0 = single-cycle memory).
- EX_CYCLES, 3, extra stall cycles per multi-cycle EX op (0 = none).
- CNT_W, 4, width of the internal wait counters; must hold max(MEM_WAIT, EX_CYCLES).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1  in  5  rs1 of instruction in ID.
- id_rs2  in  5  rs2 of instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register of instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_multi  in  1  EX instruction is multi-cycle (mul/div).
- ex_branch_taken  in  1  EX branch/jump resolved taken.
- mem_req  in  1  valid load/store currently in MEM.
- stall  out  6  stall[k]=1 holds stage k (0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB).
- flush_id  out  1  kill instruction in IF/ID register.
- flush_ex  out  1  bubble into ID/EX register.
- stall_cycles  out  32  count of cycles with stall!=0.

Behaviour:
- Stall vector is always thermometer: stall[k]=1 implies stall[j]=1 for all j<k. Legal values: 000000, 000111, 001111, 011111. stall[5] is never set.
- Downstream registers insert a bubble where stall[k]=1 and stall[k+1]=0. The controller relies on this; it does not drive bubbles itself, except via flush_ex.
- Priority is deepest source first:
  - MEM wait -> 011111;
  - else EX busy -> 001111;
  - else load-use -> 000111;
  - else 000000.
- Load-use hazard (combinational):
  - Condition: ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  - Suppressed when a flush is issued the same cycle, since the ID instruction is wrong-path.
- MEM FSM, states M_IDLE / M_WAIT, counter mcnt:
  - M_IDLE, mem_req && MEM_WAIT>0: mem stall asserted this cycle; next state M_WAIT, mcnt<=MEM_WAIT-1.
  - M_WAIT, mcnt!=0: mem stall asserted; mcnt decrements.
  - M_WAIT, mcnt==0: no mem stall, instruction leaves MEM; next state M_IDLE.
  - Net effect: each access stalls exactly MEM_WAIT cycles.
  - Back-to-back accesses each re-trigger from M_IDLE.
- EX FSM, states E_IDLE / E_BUSY, counter ecnt: same structure keyed on ex_multi with EX_CYCLES.
  - ecnt advances and the FSM transitions only in cycles where mem stall is 0.
  - While MEM stalls, the EX FSM freezes but EX stays held through the thermometer.
- Flush:
  - flush_id = flush_ex = ex_branch_taken && !stall[3].
  - A taken branch held in EX (EX busy or MEM wait) flushes on the first cycle EX is released.
  - flush_id and flush_ex are 1-cycle strobes per release.
- stall_cycles:
  - Increments on every rising edge with stall!=0.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared only by rst.
- All stall and flush outputs are combinational from FSM state and inputs, zero latency.
- Reset:
  - Both FSMs to IDLE, counters 0, stall_cycles 0.
  - While rst=1, stall=0, flush_id=0, flush_ex=0.
  - Reset mid-wait abandons the access; the first cycle after release behaves as IDLE.
- Simultaneous mem_req and ex_multi: MEM stalls first (011111 for MEM_WAIT cycles), then the EX FSM starts counting (001111 for EX_CYCLES cycles).

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> stall=000111 for exactly 1 cycle. The same stimulus with ex_rd=0 -> stall=000000.
2. MEM wait, MEM_WAIT=2: single-cycle mem_req pulse, held by stall -> stall=011111 for 2 cycles, then 000000; stall_cycles=2. Two back-to-back accesses -> 4 stalled cycles total.
3. EX multi, EX_CYCLES=3: ex_multi held -> stall=001111 for 3 cycles, then release. Add mem_req at the same time -> 011111 for 2 cycles, then 001111 for 3 cycles.
4. Branch: ex_branch_taken=1 with no stall -> flush_id=flush_ex=1 that cycle, and a coincident load-use hazard is suppressed (stall=000000). Same with ex_multi=1 -> flush held off until the cycle after EX busy ends, then a 1-cycle pulse.
5. Reset mid-wait: assert rst during M_WAIT with mcnt=1 -> outputs 0 immediately (async). After release with mem_req=0, stall=000000 and stall_cycles=0.
6. Counter wrap: preload or force stall_cycles=0xFFFFFFFF, apply one stalled cycle -> stall_cycles=0.
